seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Mealy serial-pattern detector for single-bit streams.
- Generalises fixed 5-bit detectors: pattern width set by parameter, pattern value reloadable at run time, overlap/non-overlap selectable per cycle.
- Adds a saturating match counter.
- Sits in front of framing/sync logic; consumes one qualified bit per `in_valid` cycle.

Parameters:
- PAT_W, 5, pattern length in bits; legal range 2..32.
- PAT_INIT, 5'b11101 (PAT_W bits), pattern loaded at reset. The MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit is qualified this cycle.
- in_bit  in  1  serial data bit.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled on each valid bit.
- pat_load  in  1  load pat_in as the new pattern.
- pat_in  in  PAT_W  new pattern value.
- match  out  1  Mealy match. Combinational from current inputs and registered history.
- match_cnt  out  CNT_W  saturating count of matches.
- fill  out  $clog2(PAT_W)  number of valid history bits, 0..PAT_W-1.
- pattern  out  PAT_W  currently active pattern register.

Behaviour:
- Reset: reset and clock are exactly as stated: reset reset, synchronous, active-high; clock clk.
  - When reset=1 at a rising clk edge, all of the following are applied:
    - hist <= 0
    - fill <= 0
    - match_cnt <= 0
    - pattern <= PAT_INIT
  - match is 0 while reset=1, because the output is gated by !reset.
- State:
  - hist[PAT_W-2:0] holds the last PAT_W-1 accepted bits, newest in the LSB.
  - fill is the occupancy counter, saturating at PAT_W-1.
- Candidate word = {hist, in_bit}.
- match = in_valid & !pat_load & !reset & (fill == PAT_W-1) & (candidate == pattern).
  - Latency 0: match asserts in the same cycle the final bit is presented.
- Accepted bit (in_valid=1, pat_load=0, no reset):
  - No match: hist <= {hist[PAT_W-3:0], in_bit}; fill <= min(fill+1, PAT_W-1).
  - Match with overlap=1: same shift, so the matched bits remain usable as a prefix.
  - Match with overlap=0: hist <= 0 and fill <= 0, so the next match needs PAT_W fresh bits.
  - On match, match_cnt <= match_cnt+1, saturating at all-ones and never wrapping.
- in_valid=0: no state change; match=0.
- pat_load=1:
  - pattern <= pat_in; hist <= 0; fill <= 0.
  - Any in_bit presented in the same cycle is discarded. pat_load has priority over in_valid.
  - match_cnt is unaffected.
- reset has priority over pat_load and in_valid.
- A reset mid-stream discards any partial match.
- Pattern of all-zeros or all-ones is legal:
  - With overlap=1, a continuous run matches every bit once fill is full.
- overlap may change between bits; the value sampled on the matching bit decides the history handling.

Optional Feature:
- Macro: SEQ_DET_STICKY_EN.
- Defined:
  - Adds ports `seen` (out, 1) and `seen_clr` (in, 1).
  - `seen` is registered. It is set on the clock edge after any match and held until seen_clr=1 or reset.
  - If a match and seen_clr occur in the same cycle, set wins and seen stays 1.
  - Reset value of `seen` is 0.
- Undefined:
  - Neither port exists.
  - The rest of the behaviour is identical.

Test Plan:
- Reset, then stream 1,1,1,0,1 (in_valid=1, PAT_INIT=11101, overlap=1):
  - match=0 on bits 1-4 and match=1 on bit 5.
  - match_cnt=1 after that edge; fill=4.
- Stream 1,1,1,0,1,1,1,0,1 with overlap=1:
  - match on bits 5 and 9; match_cnt=2.
  - Same stream with overlap=0: match on bit 5 only; match_cnt=1; fill=0 right after bit 5.
- Stream 1,1,0,1,1,1,0,1 with in_valid=0 bubbles inserted between every bit:
  - match only on the final valid bit.
  - No state change during bubbles.
  - Unqualified in_bit toggling during bubbles has no effect.
- After 3 valid 1s, assert pat_load=1 with pat_in=01101 and in_valid=1, in_bit=1:
  - match=0; fill=0; pattern=01101.
  - Then stream 0,1,1,0,1 gives a match on bit 5.
- CNT_W=2, pattern 11111, overlap=1, 10 consecutive 1s:
  - match on bits 5-10; match_cnt saturates at 3.
  - Synchronous reset during bit 7 clears fill/match_cnt to 0, and the next match occurs 5 valid bits after reset deasserts.

Source files
------------

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Mealy serial-pattern detector with saturating match counter
//
// Purpose:
//   Watches a qualified single-bit stream for a PAT_W-bit pattern (MSB is the
//   first bit received). Match is Mealy: it asserts in the same cycle as the
//   final pattern bit. The pattern can be reloaded at run time, and overlapping
//   or non-overlapping detection is chosen per bit. Matches are counted in a
//   saturating counter.
//
// Optional feature macro: SEQ_DET_STICKY_EN (adds seen / seen_clr sticky flag).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   in_bit is qualified this cycle
//   in_bit     in   serial data bit
//   overlap    in   1 = overlapping, 0 = non-overlapping (sampled per valid bit)
//   pat_load   in   load pat_in as new pattern (priority over in_valid)
//   pat_in     in   new pattern value
//   match      out  combinational match on the current bit
//   match_cnt  out  saturating match count
//   fill       out  number of valid history bits, 0..PAT_W-1
//   pattern    out  active pattern register
//   seen       out  sticky match flag (SEQ_DET_STICKY_EN only)
//   seen_clr   in   clears seen (SEQ_DET_STICKY_EN only)

module seq_detector_param #(
   parameter int               PAT_W    = 5,
   parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(5'b11101),
   parameter int               CNT_W    = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic                       in_bit,
   input  logic                       overlap,
   input  logic                       pat_load,
   input  logic [PAT_W-1:0]           pat_in,
   output logic                       match,
   output logic [CNT_W-1:0]           match_cnt,
   output logic [$clog2(PAT_W)-1:0]   fill,
`ifdef SEQ_DET_STICKY_EN
   output logic                       seen,
   input  logic                       seen_clr,
`endif
   output logic [PAT_W-1:0]           pattern
);

   localparam int                FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  hist_q,    hist_d;
   logic [FILL_W-1:0] fill_q,    fill_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [PAT_W-1:0]  pattern_q, pattern_d;
   logic [PAT_W-1:0]  cand;

   always_comb begin
      cand      = {hist_q, in_bit};
      match     = in_valid & ~pat_load & ~reset & (fill_q == FILL_MAX) & (cand == pattern_q);
      hist_d    = hist_q;
      fill_d    = fill_q;
      cnt_d     = cnt_q;
      pattern_d = pattern_q;

      if (pat_load) begin
         // The bit presented alongside a reload is deliberately dropped.
         pattern_d = pat_in;
         hist_d    = '0;
         fill_d    = '0;
      end else if (in_valid) begin
         if (match && !overlap) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            // Taking the low bits of the candidate works for every PAT_W >= 2,
            // including PAT_W == 2 where the history is a single bit.
            hist_d = cand[PAT_W-2:0];
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
         end
         if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q    <= '0;
         fill_q    <= '0;
         cnt_q     <= '0;
         pattern_q <= PAT_INIT;
      end else begin
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         cnt_q     <= cnt_d;
         pattern_q <= pattern_d;
      end
   end

`ifdef SEQ_DET_STICKY_EN
   logic seen_q, seen_d;

   // Set wins over clear when both happen in the same cycle.
   always_comb begin
      seen_d = seen_q;
      if (match) begin
         seen_d = 1'b1;
      end else if (seen_clr) begin
         seen_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seen_q <= 1'b0;
      end else begin
         seen_q <= seen_d;
      end
   end

   assign seen = seen_q;
`endif

   assign match_cnt = cnt_q;
   assign fill      = fill_q;
   assign pattern   = pattern_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param

module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       reset, s_reset;
   logic       in_valid, in_bit, overlap, pat_load;
   logic [4:0] pat_in;

   logic       match, s_match;
   logic [7:0] match_cnt;
   logic [1:0] s_match_cnt;
   logic [2:0] fill, s_fill;
   logic [4:0] pattern, s_pattern;
`ifdef SEQ_DET_STICKY_EN
   logic       seen, s_seen;
   logic       seen_clr;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_detector_param #(.PAT_W(5), .PAT_INIT(5'b11101), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
      .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
      .match(match), .match_cnt(match_cnt), .fill(fill),
`ifdef SEQ_DET_STICKY_EN
      .seen(seen), .seen_clr(seen_clr),
`endif
      .pattern(pattern)
   );

   seq_detector_param #(.PAT_W(5), .PAT_INIT(5'b11111), .CNT_W(2)) u_sat (
      .clk(clk), .reset(s_reset), .in_valid(in_valid), .in_bit(in_bit),
      .overlap(overlap), .pat_load(1'b0), .pat_in(pat_in),
      .match(s_match), .match_cnt(s_match_cnt), .fill(s_fill),
`ifdef SEQ_DET_STICKY_EN
      .seen(s_seen), .seen_clr(seen_clr),
`endif
      .pattern(s_pattern)
   );

   // Drive one cycle: inputs change at negedge, match is sampled 1 ns later,
   // task returns 1 ns after the rising edge so registered outputs are settled.
   task automatic drive(input logic r, input logic sr, input logic v, input logic b,
                        input logic ov, input logic pl, input logic [4:0] pi,
                        output logic m, output logic sm);
      @(negedge clk);
      reset = r; s_reset = sr; in_valid = v; in_bit = b;
      overlap = ov; pat_load = pl; pat_in = pi;
      #1;
      m  = match;
      sm = s_match;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      logic m, sm;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b0, m, sm);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b0, m, sm);
   endtask

   task automatic test_reset();
      logic m, sm;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, m, sm);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, m, sm);
      checks++; if (m !== 1'b0) begin errors++; $display("FAIL reset_match: got %b exp 0", m); end
      checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d exp 0", fill); end
      checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", match_cnt); end
      checks++; if (pattern !== 5'b11101) begin errors++; $display("FAIL reset_pattern: got %b exp 11101", pattern); end
      checks++; if (s_pattern !== 5'b11111) begin errors++; $display("FAIL reset_sat_pattern: got %b exp 11111", s_pattern); end
`ifdef SEQ_DET_STICKY_EN
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_seen: got %b exp 0", seen); end
`endif
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b0, m, sm);
   endtask

   task automatic test_basic();
      logic [4:0] bits = 5'b11101;
      logic [4:0] exp  = 5'b00001;
      logic m, sm;
      do_reset();
      for (int i = 4; i >= 0; i--) begin
         drive(1'b0, 1'b0, 1'b1, bits[i], 1'b1, 1'b0, 5'b0, m, sm);
         checks++;
         if (m !== exp[i]) begin errors++; $display("FAIL basic_match bit%0d: got %b exp %b", 5 - i, m, exp[i]); end
      end
      checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d exp 1", match_cnt); end
      checks++; if (fill !== 3'd4) begin errors++; $display("FAIL basic_fill: got %0d exp 4", fill); end
`ifdef SEQ_DET_STICKY_EN
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL basic_seen: got %b exp 1", seen); end
`endif
   endtask

   task automatic test_overlap(input logic ov);
      logic [8:0] bits    = 9'b111011101;
      logic [8:0] exp_ov  = 9'b000010001;
      logic [8:0] exp_nov = 9'b000010000;
      logic [8:0] exp;
      logic m, sm;
      exp = ov ? exp_ov : exp_nov;
      do_reset();
      for (int i = 8; i >= 0; i--) begin
         drive(1'b0, 1'b0, 1'b1, bits[i], ov, 1'b0, 5'b0, m, sm);
         checks++;
         if (m !== exp[i]) begin errors++; $display("FAIL overlap%0b_match bit%0d: got %b exp %b", ov, 9 - i, m, exp[i]); end
         if (!ov && i == 4) begin
            checks++;
            if (fill !== 3'd0) begin errors++; $display("FAIL nonoverlap_fill_after_match: got %0d exp 0", fill); end
         end
      end
      checks++;
      if (match_cnt !== (ov ? 8'd2 : 8'd1)) begin
         errors++; $display("FAIL overlap%0b_cnt: got %0d exp %0d", ov, match_cnt, ov ? 2 : 1);
      end
   endtask

   task automatic test_bubbles();
      logic [7:0] bits = 8'b11011101;
      logic [7:0] exp  = 8'b00000001;
      logic [2:0] exp_fill;
      logic m, sm;
      do_reset();
      for (int i = 7; i >= 0; i--) begin
         drive(1'b0, 1'b0, 1'b1, bits[i], 1'b1, 1'b0, 5'b0, m, sm);
         checks++;
         if (m !== exp[i]) begin errors++; $display("FAIL bubble_match bit%0d: got %b exp %b", 8 - i, m, exp[i]); end
         exp_fill = (8 - i) > 4 ? 3'd4 : 3'(8 - i);
         // Bubble carrying the complement bit, then one with the matching bit.
         drive(1'b0, 1'b0, 1'b0, ~bits[i], 1'b1, 1'b0, 5'b0, m, sm);
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b0, m, sm);
         checks++;
         if (m !== 1'b0 || fill !== exp_fill) begin
            errors++; $display("FAIL bubble_hold bit%0d: match %b fill %0d exp 0/%0d", 8 - i, m, fill, exp_fill);
         end
      end
      checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL bubble_cnt: got %0d exp 1", match_cnt); end
   endtask

   task automatic test_pat_load();
      logic [4:0] bits = 5'b01101;
      logic [4:0] exp  = 5'b00001;
      logic m, sm;
      do_reset();
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, m, sm);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'b01101, m, sm);
      checks++; if (m !== 1'b0) begin errors++; $display("FAIL load_match: got %b exp 0", m); end
      checks++; if (fill !== 3'd0) begin errors++; $display("FAIL load_fill: got %0d exp 0", fill); end
      checks++; if (pattern !== 5'b01101) begin errors++; $display("FAIL load_pattern: got %b exp 01101", pattern); end
      for (int i = 4; i >= 0; i--) begin
         drive(1'b0, 1'b0, 1'b1, bits[i], 1'b1, 1'b0, 5'b0, m, sm);
         checks++;
         if (m !== exp[i]) begin errors++; $display("FAIL load_stream bit%0d: got %b exp %b", 5 - i, m, exp[i]); end
      end
      checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL load_cnt: got %0d exp 1", match_cnt); end
   endtask

   task automatic test_saturate();
      logic [9:0] exp = 10'b0000111111;
      logic m, sm;
      do_reset();
      for (int i = 9; i >= 0; i--) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, m, sm);
         checks++;
         if (sm !== exp[i]) begin errors++; $display("FAIL sat_match bit%0d: got %b exp %b", 10 - i, sm, exp[i]); end
      end
      checks++; if (s_match_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d exp 3", s_match_cnt); end

      do_reset();
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, m, sm);
      checks++; if (s_match_cnt !== 2'd2) begin errors++; $display("FAIL sat_pre_reset_cnt: got %0d exp 2", s_match_cnt); end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, m, sm);
      checks++; if (sm !== 1'b0) begin errors++; $display("FAIL sat_reset_match: got %b exp 0", sm); end
      checks++;
      if (s_fill !== 3'd0 || s_match_cnt !== 2'd0) begin
         errors++; $display("FAIL sat_reset_clear: fill %0d cnt %0d exp 0/0", s_fill, s_match_cnt);
      end
      for (int i = 1; i <= 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, m, sm);
         checks++;
         if (sm !== (i == 5)) begin errors++; $display("FAIL sat_after_reset bit%0d: got %b exp %b", i, sm, i == 5); end
      end
   endtask

   initial begin
      reset = 1'b1; s_reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
      overlap = 1'b1; pat_load = 1'b0; pat_in = 5'b0;
`ifdef SEQ_DET_STICKY_EN
      seen_clr = 1'b0;
`endif
      test_reset();
      test_basic();
      test_overlap(1'b1);
      test_overlap(1'b0);
      test_bubbles();
      test_pat_load();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
